// File: rtl/vx_tcu_drl_acc_seq_if.sv
// ----------------------------------------------------------------------------
// vx_tcu_drl_acc_seq_if
//   Handshake bundle between the TCU issue logic, the FEDP multiply/accumulate
//   pipeline and the accumulation sequencer.
//
//   Request  : req_valid/req_ready, req_id[31:0], req_count[KW-1:0]
//   Operands : elem_valid/elem_ready (one chunk of operands per handshake)
//   Datapath : dp_valid, dp_lane_mask[N-2:0], dp_first, dp_last,
//              dp_req_id[31:0], acc_load
//   Response : rsp_valid/rsp_ready, rsp_id[31:0]
//
//   modport slave  : the sequencer's view
//   modport master : the surrounding logic's view (issue logic + datapath)
//
//   N and KW must match the sequencer instance connected to this bundle.
// ----------------------------------------------------------------------------
interface vx_tcu_drl_acc_seq_if #(
   parameter int N  = 5,
   parameter int KW = 8
);
   logic          req_valid;
   logic          req_ready;
   logic [31:0]   req_id;
   logic [KW-1:0] req_count;

   logic          elem_valid;
   logic          elem_ready;

   logic          dp_valid;
   logic [N-2:0]  dp_lane_mask;
   logic          dp_first;
   logic          dp_last;
   logic [31:0]   dp_req_id;
   logic          acc_load;

   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_id;

   modport slave (
      input  req_valid, req_id, req_count, elem_valid, rsp_ready,
      output req_ready, elem_ready, dp_valid, dp_lane_mask, dp_first,
             dp_last, dp_req_id, acc_load, rsp_valid, rsp_id
   );

   modport master (
      output req_valid, req_id, req_count, elem_valid, rsp_ready,
      input  req_ready, elem_ready, dp_valid, dp_lane_mask, dp_first,
             dp_last, dp_req_id, acc_load, rsp_valid, rsp_id
   );
endinterface

// File: rtl/vx_tcu_drl_acc_seq.sv
// ----------------------------------------------------------------------------
// vx_tcu_drl_acc_seq
//   Sequencer for the TCU FEDP accumulation datapath. A dot-product request of
//   req_count products is split into chunks of N-1 products; chunks are issued
//   one at a time, each waiting for the accumulator result (LATENCY cycles)
//   before the next may use it as its C term. One response per request.
//
//   Ports:
//     clk    : clock
//     reset  : synchronous active-high reset (drops any request in flight)
//     bus    : vx_tcu_drl_acc_seq_if.slave -- request, operand, datapath and
//              response handshakes
//
//   Parameters:
//     N       : datapath lanes including the C term (N >= 2)
//     LATENCY : chunk issue to accumulator result valid, in cycles (>= 1)
//     KW      : width of req_count
// ----------------------------------------------------------------------------
module vx_tcu_drl_acc_seq #(
   parameter int N       = 5,
   parameter int LATENCY = 2,
   parameter int KW      = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   vx_tcu_drl_acc_seq_if.slave   bus
);
   localparam int LANES = N - 1;
   // Largest chunk count a single request can need; counters never wrap.
   localparam int MAXCH = ((2 ** KW) - 1 + LANES - 1) / LANES;
   localparam int CW    = (MAXCH > 1) ? $clog2(MAXCH + 1) : 1;
   localparam int WW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]       r_state;
   logic [CW-1:0]    r_chunk_idx;   // index of the chunk to issue next
   logic [CW-1:0]    r_last_idx;    // index of the final chunk
   logic [WW-1:0]    r_wait;
   logic [31:0]      r_tag;
   logic [LANES-1:0] r_tail_mask;   // lane mask for the final chunk

   logic [CW-1:0]    w_last_idx;
   logic [31:0]      w_rem;
   logic [LANES-1:0] w_tail_mask;
   logic             w_issue;
   logic             w_is_last;
   logic             w_load;

   // Final chunk index: ceil(count/LANES)-1, with a zero count still issuing
   // one chunk so the C term passes through.
   always_comb begin
      w_last_idx = '0;
      if (bus.req_count != '0) begin
         w_last_idx = CW'((32'(bus.req_count) + 32'(LANES) - 32'd1) / 32'(LANES) - 32'd1);
      end
   end

   assign w_rem = 32'(bus.req_count) % 32'(LANES);

   // Tail mask: low rem lanes, all lanes when rem is 0, none for a zero count.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_tail
         assign w_tail_mask[gi] = (bus.req_count != '0) &&
                                  ((w_rem == 32'd0) || (32'(gi) < w_rem));
      end
   endgenerate

   assign w_issue   = (r_state == S_ISSUE) && bus.elem_valid;
   assign w_is_last = (r_chunk_idx == r_last_idx);
   assign w_load    = (r_state == S_WAIT) && (r_wait == WW'(LATENCY - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_chunk_idx <= '0;
         r_last_idx  <= '0;
         r_wait      <= '0;
         r_tag       <= '0;
         r_tail_mask <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_tag       <= bus.req_id;
                  r_last_idx  <= w_last_idx;
                  r_tail_mask <= w_tail_mask;
                  r_chunk_idx <= '0;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (bus.elem_valid) begin
                  r_wait  <= '0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               // Leave on the load cycle so the next chunk issues right after
               // the accumulator has been written back.
               if (w_load) begin
                  if (w_is_last) begin
                     r_state <= S_RESP;
                  end else begin
                     r_chunk_idx <= r_chunk_idx + 1'b1;
                     r_state     <= S_ISSUE;
                  end
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            default: begin
               if (bus.rsp_ready) begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.req_ready    = (r_state == S_IDLE);
   assign bus.elem_ready   = (r_state == S_ISSUE);
   assign bus.dp_valid     = w_issue;
   assign bus.dp_lane_mask = !w_issue ? '0 : (w_is_last ? r_tail_mask : '1);
   assign bus.dp_first     = w_issue && (r_chunk_idx == '0);
   assign bus.dp_last      = w_issue && w_is_last;
   assign bus.dp_req_id    = w_issue ? r_tag : '0;
   assign bus.acc_load     = w_load;
   assign bus.rsp_valid    = (r_state == S_RESP);
   assign bus.rsp_id       = (r_state == S_RESP) ? r_tag : '0;
endmodule

// File: tb/tb_vx_tcu_drl_acc_seq.sv
// ----------------------------------------------------------------------------
// tb_vx_tcu_drl_acc_seq
//   Directed bench for the accumulation sequencer (N=5, LATENCY=2, KW=8).
//   A timeline model (earliest issue cycle, load cycle, response cycle) is
//   compared with the DUT on every cycle; per-test event logs are also
//   compared with hand-computed cycle numbers.
// ----------------------------------------------------------------------------
module tb_vx_tcu_drl_acc_seq;
   localparam int N     = 5;
   localparam int LAT   = 2;
   localparam int KW    = 8;
   localparam int LANES = N - 1;

   logic clk = 1'b0;
   logic reset = 1'b1;

   vx_tcu_drl_acc_seq_if #(.N(N), .KW(KW)) bus ();

   vx_tcu_drl_acc_seq #(.N(N), .LATENCY(LAT), .KW(KW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, $signed(act), $signed(exp));
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -99;
   endfunction

   // ---------------- timeline model ----------------
   bit          m_busy = 1'b0;
   int          m_count, m_total, m_issued, m_next_issue;
   int          m_load_at = -1;
   int          m_resp_at = -1;
   logic [31:0] m_tag;

   function automatic logic [LANES-1:0] exp_mask(input int count, input int k, input int total);
      int rem;
      if (k != total - 1) return {LANES{1'b1}};
      if (count == 0) return '0;
      rem = count % LANES;
      if (rem == 0) return {LANES{1'b1}};
      return LANES'((1 << rem) - 1);
   endfunction

   logic             e_rr, e_er, e_dv, e_first, e_last, e_load, e_rv;
   logic [LANES-1:0] e_mask;
   logic [31:0]      e_id;

   // ---------------- per-test capture ----------------
   int   t0 = 1 << 20;
   int   dp_q[$], mask_q[$], first_q[$], last_q[$], ld_q[$], acc_q[$];
   int   first_rsp;
   logic rr[32], er[32], rv[32], nz[32];

   always @(negedge clk) begin
      int rel;
      e_rr    = !m_busy;
      e_er    = m_busy && (m_issued < m_total) && (cyc >= m_next_issue);
      e_dv    = e_er && bus.elem_valid;
      e_mask  = e_dv ? exp_mask(m_count, m_issued, m_total) : '0;
      e_first = e_dv && (m_issued == 0);
      e_last  = e_dv && (m_issued == m_total - 1);
      e_id    = e_dv ? m_tag : 32'd0;
      e_load  = m_busy && (cyc == m_load_at);
      e_rv    = m_busy && (m_resp_at >= 0) && (cyc >= m_resp_at);

      if (chk_en) begin
         chk("req_ready",    64'(bus.req_ready),    64'(e_rr));
         chk("elem_ready",   64'(bus.elem_ready),   64'(e_er));
         chk("dp_valid",     64'(bus.dp_valid),     64'(e_dv));
         chk("dp_lane_mask", 64'(bus.dp_lane_mask), 64'(e_mask));
         chk("dp_first",     64'(bus.dp_first),     64'(e_first));
         chk("dp_last",      64'(bus.dp_last),      64'(e_last));
         chk("dp_req_id",    64'(bus.dp_req_id),    64'(e_id));
         chk("acc_load",     64'(bus.acc_load),     64'(e_load));
         chk("rsp_valid",    64'(bus.rsp_valid),    64'(e_rv));
         if (e_rv) chk("rsp_id", 64'(bus.rsp_id), 64'(m_tag));
      end

      // capture actual DUT events relative to the test's accept cycle
      rel = cyc - t0;
      if (rel >= 0) begin
         if (rel < 32) begin
            rr[rel] = bus.req_ready;
            er[rel] = bus.elem_ready;
            rv[rel] = bus.rsp_valid;
            nz[rel] = |{bus.elem_ready, bus.dp_valid, bus.dp_lane_mask, bus.dp_first,
                        bus.dp_last, bus.dp_req_id, bus.acc_load, bus.rsp_valid, bus.rsp_id};
         end
         if (bus.dp_valid === 1'b1) begin
            dp_q.push_back(rel);
            mask_q.push_back(int'(bus.dp_lane_mask));
            first_q.push_back(int'(bus.dp_first));
            last_q.push_back(int'(bus.dp_last));
         end
         if (bus.acc_load === 1'b1) ld_q.push_back(rel);
         if (bus.rsp_valid === 1'b1 && first_rsp < 0) first_rsp = rel;
         if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) acc_q.push_back(rel);
      end

      // advance the model across the coming clock edge
      if (reset) begin
         m_busy    = 1'b0;
         m_load_at = -1;
         m_resp_at = -1;
      end else begin
         if (e_dv) begin
            m_issued++;
            m_load_at    = cyc + LAT;
            m_next_issue = cyc + LAT + 1;
            if (m_issued == m_total) m_resp_at = cyc + LAT + 1;
         end
         if (e_rv && bus.rsp_ready) m_busy = 1'b0;
         if (e_rr && bus.req_valid) begin
            m_busy       = 1'b1;
            m_count      = int'(bus.req_count);
            m_total      = (m_count == 0) ? 1 : (m_count + LANES - 1) / LANES;
            m_issued     = 0;
            m_next_issue = cyc + 1;
            m_load_at    = -1;
            m_resp_at    = -1;
            m_tag        = bus.req_id;
         end
      end
   end

   // ---------------- stimulus ----------------
   // rel 0 presents the request; inputs are then shaped per relative cycle.
   task automatic run_req(input int count, input logic [31:0] id,
                          input int stall_lo, input int stall_hi, input int rsp_from,
                          input int reset_at, input int req2_from, input int count2,
                          input int ncyc);
      dp_q.delete(); mask_q.delete(); first_q.delete(); last_q.delete();
      ld_q.delete(); acc_q.delete();
      first_rsp = -1;
      foreach (rr[i]) begin rr[i] = 1'bx; er[i] = 1'bx; rv[i] = 1'bx; nz[i] = 1'bx; end
      t0 = cyc;
      for (int rel = 0; rel < ncyc; rel++) begin
         bus.req_valid  = (rel == 0) || (req2_from >= 0 && rel >= req2_from && acc_q.size() < 2);
         bus.req_id     = (rel == 0) ? id : id + 32'd1;
         bus.req_count  = (rel == 0) ? KW'(count) : KW'(count2);
         bus.elem_valid = !(rel >= stall_lo && rel <= stall_hi);
         bus.rsp_ready  = (rel >= rsp_from);
         reset          = (rel == reset_at);
         $display("cyc %0d rel %0d: req_valid=%0b elem_valid=%0b rsp_ready=%0b reset=%0b",
                  cyc, rel, bus.req_valid, bus.elem_valid, bus.rsp_ready, reset);
         @(posedge clk); #1;
      end
      bus.req_valid  = 1'b0;
      bus.elem_valid = 1'b1;
      bus.rsp_ready  = 1'b1;
      reset          = 1'b0;
   endtask

   task automatic check_full8(input string tag);
      chk({tag, "_dp_n"},    64'(dp_q.size()), 64'(2));
      chk({tag, "_dp0"},     64'(qget(dp_q, 0)), 64'(1));
      chk({tag, "_dp1"},     64'(qget(dp_q, 1)), 64'(4));
      chk({tag, "_mask0"},   64'(qget(mask_q, 0)), 64'(15));
      chk({tag, "_mask1"},   64'(qget(mask_q, 1)), 64'(15));
      chk({tag, "_first0"},  64'(qget(first_q, 0)), 64'(1));
      chk({tag, "_first1"},  64'(qget(first_q, 1)), 64'(0));
      chk({tag, "_last0"},   64'(qget(last_q, 0)), 64'(0));
      chk({tag, "_last1"},   64'(qget(last_q, 1)), 64'(1));
      chk({tag, "_ld0"},     64'(qget(ld_q, 0)), 64'(3));
      chk({tag, "_ld1"},     64'(qget(ld_q, 1)), 64'(6));
      chk({tag, "_rsp"},     64'(first_rsp), 64'(7));
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_id     = '0;
      bus.req_count  = '0;
      bus.elem_valid = 1'b1;
      bus.rsp_ready  = 1'b1;
      reset          = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
      chk("rst_others", 64'(|{bus.elem_ready, bus.dp_valid, bus.dp_lane_mask, bus.dp_first,
                              bus.dp_last, bus.dp_req_id, bus.acc_load, bus.rsp_valid,
                              bus.rsp_id}), 64'(0));
      @(posedge clk); #1;

      // full chunks, req_count=8
      run_req(8, 32'hA1, 99, -1, 0, -1, -1, 0, 10);
      check_full8("full8");

      // tail mask, req_count=6
      run_req(6, 32'hB2, 99, -1, 0, -1, -1, 0, 10);
      chk("tail_dp_n",  64'(dp_q.size()), 64'(2));
      chk("tail_mask1", 64'(qget(mask_q, 1)), 64'(3));
      chk("tail_last1", 64'(qget(last_q, 1)), 64'(1));
      chk("tail_rsp",   64'(first_rsp), 64'(7));

      // zero count
      run_req(0, 32'hC3, 99, -1, 0, -1, -1, 0, 8);
      chk("zero_dp_n",  64'(dp_q.size()), 64'(1));
      chk("zero_dp0",   64'(qget(dp_q, 0)), 64'(1));
      chk("zero_mask0", 64'(qget(mask_q, 0)), 64'(0));
      chk("zero_first", 64'(qget(first_q, 0)), 64'(1));
      chk("zero_last",  64'(qget(last_q, 0)), 64'(1));
      chk("zero_ld0",   64'(qget(ld_q, 0)), 64'(3));
      chk("zero_rsp",   64'(first_rsp), 64'(4));

      // operand stall, elem_valid low cycles 1-3
      run_req(4, 32'hD4, 1, 3, 0, -1, -1, 0, 10);
      chk("stall_er1",  64'(er[1]), 64'(1));
      chk("stall_er2",  64'(er[2]), 64'(1));
      chk("stall_er3",  64'(er[3]), 64'(1));
      chk("stall_dp_n", 64'(dp_q.size()), 64'(1));
      chk("stall_dp0",  64'(qget(dp_q, 0)), 64'(4));
      chk("stall_ld0",  64'(qget(ld_q, 0)), 64'(6));
      chk("stall_rsp",  64'(first_rsp), 64'(7));

      // response backpressure, second request waiting from cycle 5
      run_req(4, 32'hE5, 99, -1, 10, -1, 5, 8, 20);
      chk("bp_rsp",    64'(first_rsp), 64'(4));
      chk("bp_rv10",   64'(rv[10]), 64'(1));
      chk("bp_rv11",   64'(rv[11]), 64'(0));
      chk("bp_rr10",   64'(rr[10]), 64'(0));
      chk("bp_rr11",   64'(rr[11]), 64'(1));
      chk("bp_acc_n",  64'(acc_q.size()), 64'(2));
      chk("bp_acc2",   64'(qget(acc_q, 1)), 64'(11));

      // reset mid-operation (in WAIT at cycle 5)
      run_req(12, 32'hF6, 99, -1, 0, 5, -1, 0, 10);
      chk("rst_dp_n",  64'(dp_q.size()), 64'(2));
      chk("rst_ld_n",  64'(ld_q.size()), 64'(1));
      chk("rst_ld0",   64'(qget(ld_q, 0)), 64'(3));
      chk("rst_rsp",   64'(first_rsp), 64'(-1));
      chk("rst_rr6",   64'(rr[6]), 64'(1));
      chk("rst_nz6",   64'(nz[6]), 64'(0));

      // next request after reset behaves like the full-chunks case
      run_req(8, 32'h17, 99, -1, 0, -1, -1, 0, 10);
      check_full8("after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/vx_tcu_drl_acc_seq.md
Name: VX_tcu_drl_acc_seq

Overview:
- Sequencer for the TCU FEDP accumulation datapath.
- Splits a dot-product request of arbitrary length into chunks of N-1 products each, and issues the chunks in order.
- Drives the per-chunk lane mask and C-term select, and the result-register load strobe, honouring the loop-carried dependency through the accumulator.
- Returns one response per request. Sits between the TCU issue logic and the FEDP multiply/accumulate pipeline.

Parameters:
- N, 5: datapath lanes including C term; N-1 product lanes per chunk (N >= 2).
- LATENCY, 2: cycles from chunk issue to accumulator result valid (>= 1).
- KW, 8: width of the product-count field.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  new dot-product request
- req_ready  out  1  request accepted when valid&&ready
- req_id  in  32  request tag
- req_count  in  KW  number of products in request
- elem_valid  in  1  upstream has next chunk operands
- elem_ready  out  1  chunk consumed when elem_valid&&elem_ready
- dp_valid  out  1  chunk issued to datapath this cycle
- dp_lane_mask  out  N-1  product-lane enable for issued chunk
- dp_first  out  1  C lane takes external C (1) or fed-back accumulator (0)
- dp_last  out  1  final chunk of request
- dp_req_id  out  32  tag of issued chunk
- acc_load  out  1  result register load strobe
- rsp_valid  out  1  accumulated result ready
- rsp_ready  in  1  response consumed
- rsp_id  out  32  tag of completed request

Behaviour:
- Reset (sync, active-high, any state): FSM -> IDLE; chunk counter, wait counter and tag cleared. Every output is 0 except req_ready, which is 1 in IDLE. Operations in flight are dropped with no response. Reset has priority over all handshakes in the same cycle.
- Chunk math:
  - chunks = ceil(req_count/(N-1)); req_count=0 is treated as 1 chunk with dp_lane_mask all-zero, so only the C term passes through.
  - rem = req_count mod (N-1).
  - Every chunk except the last gets mask all-ones. The last chunk gets the low rem bits set, or all-ones if rem=0.
  - Counters are sized to hold ceil((2^KW-1)/(N-1)); no wrap within a request.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On accept: latch req_id/chunks/rem, go to ISSUE next cycle.
- ISSUE:
  - elem_ready=1.
  - On elem_valid: dp_valid=1 with mask/dp_first/dp_last/dp_req_id valid in the same cycle, then go to WAIT.
  - dp_first=1 only on chunk 0.
  - elem_valid low: stay in ISSUE, all dp_* outputs 0.
- WAIT:
  - Count LATENCY cycles; acc_load=1 exactly LATENCY cycles after the dp_valid cycle.
  - In the cycle after acc_load: go to ISSUE if chunks remain, else to RESP.
  - Issue-to-issue spacing is therefore LATENCY+1 cycles minimum.
  - elem_ready=0 throughout WAIT.
- RESP:
  - rsp_valid=1, rsp_id=latched tag.
  - rsp_valid and rsp_id hold stable until rsp_ready; on rsp_ready go to IDLE next cycle.
  - req_ready=0 in RESP, so there is no same-cycle re-accept and the block has a single outstanding request.
- Outputs are registered; dp_* are driven combinationally from registered state and elem_valid only.
- acc_load never asserts outside WAIT; dp_valid never asserts outside ISSUE.

Test Plan (N=5, LATENCY=2; request accepted at cycle 0; elem_valid=1 unless stated):
- Full chunks, req_count=8:
  - Chunk 0 issued at cycle 1: dp_valid, mask=1111, dp_first=1, dp_last=0.
  - acc_load at cycle 3.
  - Chunk 1 issued at cycle 4: mask=1111, dp_first=0, dp_last=1.
  - acc_load at cycle 6; rsp_valid at cycle 7.
- Tail mask, req_count=6: chunk 1 mask=0011, dp_last=1; rsp_valid at cycle 7; exactly 2 dp_valid pulses.
- Zero count, req_count=0: single chunk at cycle 1 with mask=0000, dp_first=1 and dp_last=1; acc_load at cycle 3; rsp_valid at cycle 4.
- Operand stall, req_count=4, elem_valid low cycles 1-3: elem_ready held 1; dp_valid only at cycle 4; acc_load at cycle 6; rsp_valid at cycle 7.
- Response backpressure, req_count=4, rsp_ready low until cycle 10:
  - rsp_valid held from cycle 4 to cycle 10 with rsp_id stable.
  - req_ready=0 until cycle 11; new request accepted at cycle 11.
- Reset mid-op, req_count=12, reset at cycle 5 (in WAIT):
  - Cycle 6: all outputs 0, req_ready=1; no acc_load or rsp_valid for the dropped request.
  - Next request behaves as in the full-chunks case.
